// File: rtl/flappy_pkg.sv
// flappy_pkg: shared framebuffer constants and the buffer controller state type.
package flappy_pkg;
    localparam int H_DEFAULT = 480;
    localparam int V_DEFAULT = 272;
    typedef enum logic [1:0] {CLEAR, RUN, SWAP_HOLD} fb_state_t;
endpackage

// File: rtl/frame_buffer_ram.sv
// frame_buffer_ram: 1-bit simple dual-port RAM, one write port and one synchronous read port.
module frame_buffer_ram
    import flappy_pkg::*;
#(
    parameter int DEPTH  = H_DEFAULT * V_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic              rdata
);
    logic mem [DEPTH];
    // Read output only moves on an enabled read so the pixel holds between requests.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/double_frame_buffer.sv
// double_frame_buffer: two 1-bpp framebuffers; renderer fills the back one while scanout reads
// the front one, exchanged at vblank when the back frame is complete.
module double_frame_buffer
    import flappy_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = H_DEFAULT,
    parameter int VER_ACTIVE_PIXELS = V_DEFAULT,
    localparam int PIXELS = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS,
    localparam int ADDR_W = $clog2(PIXELS),
    localparam int X_W    = $clog2(HOR_ACTIVE_PIXELS),
    localparam int Y_W    = $clog2(VER_ACTIVE_PIXELS)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data,
    input  logic              back_ready,
    input  logic              frame_start,
    input  logic              rd_en,
    input  logic [X_W-1:0]    rd_x,
    input  logic [Y_W-1:0]    rd_y,
    output logic              rd_data,
    output logic              rd_valid,
    output logic              swap,
    output logic              front_sel
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PIXELS - 1);

    fb_state_t         state;
    logic [ADDR_W-1:0] clr_addr;
    logic              pending;
    logic              clearing, wr_ok, we0, we1, wdata, rd_oor;
    logic [ADDR_W-1:0] waddr, rd_addr;
    logic [ADDR_W-1:0] addr1;
    logic              zero1, sel1, v1, zero2, sel2, q0, q1;

    assign clearing = state == CLEAR;
    assign wr_ok    = !clearing && wr_en && wr_addr <= LAST;
    // Back buffer is the one not being displayed; clearing hits both at once.
    assign we0      = clearing || (wr_ok && front_sel);
    assign we1      = clearing || (wr_ok && !front_sel);
    assign waddr    = clearing ? clr_addr : wr_addr;
    assign wdata    = !clearing && wr_data;
    assign rd_oor   = {1'b0, rd_x} >= (X_W+1)'(HOR_ACTIVE_PIXELS) ||
                      {1'b0, rd_y} >= (Y_W+1)'(VER_ACTIVE_PIXELS);
    assign rd_addr  = ADDR_W'(rd_y) * ADDR_W'(HOR_ACTIVE_PIXELS) + ADDR_W'(rd_x);
    assign swap     = pending;
    assign rd_data  = zero2 ? 1'b0 : (sel2 ? q1 : q0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            front_sel <= 1'b0;
            pending   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr == LAST ? '0 : clr_addr + ADDR_W'(1);
                    if (clr_addr == LAST) state <= RUN;
                end
                RUN: if (frame_start && back_ready) begin
                    front_sel <= ~front_sel;
                    pending   <= 1'b1;
                    state     <= SWAP_HOLD;
                end
                SWAP_HOLD: if (ce) begin
                    pending <= 1'b0;
                    state   <= RUN;
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Stage 1 latches address/flags, stage 2 is the RAM read itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr1    <= '0;
            zero1    <= 1'b1;
            sel1     <= 1'b0;
            v1       <= 1'b0;
            zero2    <= 1'b1;
            sel2     <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            v1       <= rd_en;
            rd_valid <= v1;
            if (rd_en) begin
                addr1 <= rd_addr;
                zero1 <= rd_oor || clearing;
                sel1  <= front_sel;
            end
            if (v1) begin
                zero2 <= zero1;
                sel2  <= sel1;
            end
        end
    end

    frame_buffer_ram #(.DEPTH(PIXELS), .ADDR_W(ADDR_W)) buf0 (
        .clk(clk), .we(we0), .waddr(waddr), .wdata(wdata),
        .re(v1), .raddr(addr1), .rdata(q0)
    );

    frame_buffer_ram #(.DEPTH(PIXELS), .ADDR_W(ADDR_W)) buf1 (
        .clk(clk), .we(we1), .waddr(waddr), .wdata(wdata),
        .re(v1), .raddr(addr1), .rdata(q1)
    );
endmodule
